// File: rtl/aes_stream_pkg.sv
// Shared types and helpers for the 512-bit AES inverse-cipher stream stages.
package aes_stream_pkg;

  localparam int DATA_W = 512;

  typedef logic [DATA_W-1:0] beat_t;

  // Counter width able to hold the values 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/aes_sync_fifo.sv
// First-word-fall-through FIFO: circular storage, pointers and occupancy.
module aes_sync_fifo
  import aes_stream_pkg::*;
#(
  parameter int  DEPTH = 16,
  parameter type T     = beat_t,
  parameter int  CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop_req,
  input  T                 wdata,
  output T                 rdata,
  output logic             empty,
  output logic             overflow,
  output logic [CNT_W-1:0] fill,
  output logic [CNT_W-1:0] fill_next
);

  localparam int AW = $clog2(DEPTH);

  T                 r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_fill;

  logic w_full;
  logic w_pop;
  logic w_push;

  assign empty  = (r_fill == '0);
  assign w_full = (r_fill == CNT_W'(DEPTH));
  assign w_pop  = pop_req && !empty;
  // A full FIFO still takes a beat when the head leaves in the same cycle.
  assign w_push   = push && (!w_full || w_pop);
  assign overflow = push && w_full && !w_pop;

  assign fill_next = r_fill + CNT_W'(w_push) - CNT_W'(w_pop);
  assign fill      = r_fill;
  // Gating on empty keeps stale entries invisible after a reset.
  assign rdata     = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_fill <= fill_next;
    end
  end

  // NOTE: storage is deliberately not reset; validity is tracked by fill alone.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wdata;
  end

endmodule

// File: rtl/aes_dec_out_buffer.sv
// Output buffer after the AES inverse cipher: FWFT FIFO plus credit/in-flight accounting.
module aes_dec_out_buffer #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = aes_stream_pkg::DATA_W,
  parameter int CNT_W  = aes_stream_pkg::cnt_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue,
  output logic              credit_ok,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  fill,
  output logic [CNT_W-1:0]  inflight,
  output logic              err_overflow,
  output logic              err_underflow
);

  typedef logic [DATA_W-1:0] word_t;

  logic             w_empty;
  logic             w_pop;
  logic             w_overflow;
  logic             w_underflow;
  logic [CNT_W-1:0] w_fill_next;
  logic [CNT_W-1:0] w_inflight_next;
  logic [CNT_W:0]   w_committed;

  logic [CNT_W-1:0] r_inflight;
  logic             r_credit_ok;
  logic             r_err_overflow;
  logic             r_err_underflow;

  assign out_valid = !w_empty;
  assign w_pop     = out_valid && out_ready;

  aes_sync_fifo #(
    .DEPTH (DEPTH),
    .T     (word_t),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_valid),
    .pop_req   (w_pop),
    .wdata     (in_data),
    .rdata     (out_data),
    .empty     (w_empty),
    .overflow  (w_overflow),
    .fill      (fill),
    .fill_next (w_fill_next)
  );

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    w_underflow     = in_valid && (r_inflight == '0);
    w_inflight_next = r_inflight;
    if (issue && !in_valid) begin
      w_inflight_next = r_inflight + CNT_W'(1);
    end else if (!issue && in_valid && !w_underflow) begin
      w_inflight_next = r_inflight - CNT_W'(1);
    end
  end

  // Credit is judged on next-state totals so a launch seen with credit_ok high is always covered.
  assign w_committed = {1'b0, w_fill_next} + {1'b0, w_inflight_next};

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight      <= '0;
      r_credit_ok     <= 1'b1;
      r_err_overflow  <= 1'b0;
      r_err_underflow <= 1'b0;
    end else begin
      r_inflight  <= w_inflight_next;
      r_credit_ok <= (w_committed < (CNT_W+1)'(DEPTH));
      if (w_overflow)  r_err_overflow  <= 1'b1;
      if (w_underflow) r_err_underflow <= 1'b1;
    end
  end

  assign inflight      = r_inflight;
  assign credit_ok     = r_credit_ok;
  assign err_overflow  = r_err_overflow;
  assign err_underflow = r_err_underflow;

endmodule

// File: tb/tb_aes_dec_out_buffer.sv
// Randomised and directed bench for aes_dec_out_buffer against a queue-based reference model.
module tb_aes_dec_out_buffer;
  import aes_stream_pkg::*;

  localparam int DEPTH = 16;
  localparam int CNT_W = cnt_width(DEPTH);

  logic             clk = 1'b0;
  logic             rst;
  logic             issue;
  logic             credit_ok;
  logic             in_valid;
  beat_t            in_data;
  logic             out_valid;
  logic             out_ready;
  beat_t            out_data;
  logic [CNT_W-1:0] fill;
  logic [CNT_W-1:0] inflight;
  logic             err_overflow;
  logic             err_underflow;

  always #5 clk = ~clk;

  aes_dec_out_buffer #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .issue         (issue),
    .credit_ok     (credit_ok),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .fill          (fill),
    .inflight      (inflight),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: the buffer is just an ordered queue of beats.
  beat_t m_q[$];
  int    m_inflight;
  bit    m_credit;
  bit    m_ovf;
  bit    m_unf;

  int    cyc = 0;
  int    pend[$];

  task automatic check(input string tag, input beat_t obs, input beat_t exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic beat_t rnd_beat();
    beat_t b;
    for (int i = 0; i < DATA_W / 32; i++) b[i*32 +: 32] = $urandom();
    return b;
  endfunction

  task automatic model_step(input bit iss, input bit iv, input beat_t d,
                            input bit ordy, input bit rs);
    bit pop;
    int size_before;
    if (rs) begin
      m_q.delete();
      m_inflight = 0;
      m_credit   = 1'b1;
      m_ovf      = 1'b0;
      m_unf      = 1'b0;
    end else begin
      size_before = m_q.size();
      pop = ordy && (size_before > 0);
      if (pop) void'(m_q.pop_front());
      if (iv) begin
        if (size_before < DEPTH || pop) m_q.push_back(d);
        else m_ovf = 1'b1;
      end
      if (iv && m_inflight == 0) m_unf = 1'b1;
      if (iss && !iv) m_inflight++;
      else if (!iss && iv && m_inflight > 0) m_inflight--;
      m_credit = (m_q.size() + m_inflight) < DEPTH;
    end
  endtask

  task automatic compare_all();
    check("fill",          beat_t'(fill),          beat_t'(m_q.size()));
    check("inflight",      beat_t'(inflight),      beat_t'(m_inflight));
    check("out_valid",     beat_t'(out_valid),     beat_t'(m_q.size() > 0));
    check("out_data",      out_data,               (m_q.size() > 0) ? m_q[0] : '0);
    check("credit_ok",     beat_t'(credit_ok),     beat_t'(m_credit));
    check("err_overflow",  beat_t'(err_overflow),  beat_t'(m_ovf));
    check("err_underflow", beat_t'(err_underflow), beat_t'(m_unf));
  endtask

  // One clock: apply inputs, let the edge pass, advance the model, compare 1 time unit later.
  task automatic drive(input bit iss, input bit iv, input beat_t d,
                       input bit ordy, input bit rs);
    issue     = iss;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    rst       = rs;
    @(posedge clk);
    model_step(iss, iv, d, ordy, rs);
    #1;
    cyc++;
    compare_all();
  endtask

  // Beats scheduled by the emulated cipher come back when their return cycle arrives.
  function automatic bit return_due();
    return (pend.size() > 0) && (pend[0] == cyc);
  endfunction

  initial begin
    int n_iss;
    bit iv;
    bit iss;
    issue = 0; in_valid = 0; in_data = '0; out_ready = 0; rst = 1;

    // Reset state.
    drive(0, 0, '0, 0, 1);
    drive(0, 0, '0, 0, 1);

    // Four beats through a 20-cycle cipher, consumer always ready.
    for (int c = 0; c < 30; c++) begin
      iss = (c < 4);
      iv  = (c >= 20 && c < 24);
      drive(iss, iv, iv ? beat_t'(c - 19) : '0, 1, 0);
    end
    check("t1_fill_end", beat_t'(fill), '0);
    check("t1_inflight_end", beat_t'(inflight), '0);
    check("t1_credit_end", beat_t'(credit_ok), beat_t'(1));

    // Fill to capacity with the consumer stalled; issue only while credit is granted.
    n_iss = 0;
    pend.delete();
    for (int c = 0; c < 45; c++) begin
      iss = (c < 20) && credit_ok;
      if (iss) begin
        n_iss++;
        pend.push_back(cyc + 20);
      end
      iv = return_due();
      if (iv) void'(pend.pop_front());
      drive(iss, iv, iv ? rnd_beat() : '0, 0, 0);
    end
    check("t2_issues", beat_t'(n_iss), beat_t'(DEPTH));
    check("t2_fill_full", beat_t'(fill), beat_t'(DEPTH));
    check("t2_no_overflow", beat_t'(err_overflow), '0);

    // Full: forced beat with no pop is dropped; forced beat with pop is taken at the wrapped slot.
    drive(0, 1, rnd_beat(), 0, 0);
    check("t3_overflow_set", beat_t'(err_overflow), beat_t'(1));
    drive(0, 1, rnd_beat(), 1, 0);
    check("t3_fill_kept", beat_t'(fill), beat_t'(DEPTH));
    for (int c = 0; c < 20; c++) drive(0, 0, '0, 1, 0);
    check("t3_overflow_sticky", beat_t'(err_overflow), beat_t'(1));

    // Underflow on a clean buffer: flag set, inflight held at zero, beat still stored.
    drive(0, 0, '0, 0, 1);
    drive(0, 1, rnd_beat(), 0, 0);
    check("t4_underflow", beat_t'(err_underflow), beat_t'(1));
    check("t4_inflight_zero", beat_t'(inflight), '0);
    drive(0, 0, '0, 1, 0);
    drive(0, 0, '0, 1, 0);

    // Reset in the middle of traffic discards everything.
    drive(0, 0, '0, 0, 1);
    for (int c = 0; c < 12; c++) drive(1, 0, '0, 0, 0);
    for (int c = 0; c < 7; c++)  drive(0, 1, rnd_beat(), 0, 0);
    check("t5_fill7", beat_t'(fill), beat_t'(7));
    check("t5_inflight5", beat_t'(inflight), beat_t'(5));
    drive(0, 0, '0, 0, 1);
    check("t5_rst_fill", beat_t'(fill), '0);
    check("t5_rst_valid", beat_t'(out_valid), '0);
    for (int c = 0; c < 5; c++) drive(0, 0, '0, 1, 0);

    // Randomised traffic through a 6-cycle cipher with a bursty consumer.
    pend.delete();
    for (int c = 0; c < 1500; c++) begin
      iss = credit_ok && ($urandom_range(0, 3) != 0);
      if (iss) pend.push_back(cyc + 6);
      iv = return_due();
      if (iv) void'(pend.pop_front());
      drive(iss, iv, iv ? rnd_beat() : '0, $urandom_range(0, 2) != 0, 0);
    end
    for (int c = 0; c < 40; c++) begin
      iv = return_due();
      if (iv) void'(pend.pop_front());
      drive(0, iv, iv ? rnd_beat() : '0, 1, 0);
    end
    check("t6_drained", beat_t'(fill), '0);
    check("t6_no_overflow", beat_t'(err_overflow), '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
